kbd_matrix: RTL and testbench
=============================

KBD_MATRIX -- requirements
Module: kbd_matrix

Interface
REQ-001 SHALL have parameter NUM_COLS, default 8: number of matrix columns, range 2..16.
REQ-002 SHALL have parameter NUM_ROWS, default 8: number of matrix rows, range 1..16.
REQ-003 SHALL have parameter STRETCH, default 16: minimum swrst/swnmi assertion in clk_24 cycles, ≥1.
REQ-004 SHALL have parameter STUCK_TICKS, default 65535: clk_en ticks without a strobe, while any key is held, before the auto-release fires; 0 disables it.
REQ-005 SHALL have port clk_24 in 1: the single clock.
REQ-006 SHALL have port reset_n in 1: asynchronous, active-low reset.
REQ-007 SHALL have port clk_en in 1: matrix sample enable.
REQ-008 SHALL have port key_strobe in 1: one-cycle PS/2 event valid.
REQ-009 SHALL have port key_pressed in 1: 1 = make, 0 = break.
REQ-010 SHALL have port key_extended in 1: E0-prefixed code.
REQ-011 SHALL have port key_code in 8: scan code.
REQ-012 SHALL have port release_all in 1: level, clears every held key.
REQ-013 SHALL have port col in $clog2(NUM_COLS): selected column.
REQ-014 SHALL have port row_n out NUM_ROWS: active-low row sense for the selected column.
REQ-015 SHALL have port any_key out 1: high while any matrix key is held.
REQ-016 SHALL have port swrst out 1: stretched reset request.
REQ-017 SHALL have port swnmi out 1: stretched NMI pulse.

Function
REQ-018 SHALL translate {key_extended, key_code} to {hit, col, row} or to special key RST (F11 = 0x78) or NMI (F10 = 0x09) through the keymap; unmapped codes are ignored.
REQ-019 SHALL qualify on key_extended: a mapped non-extended code received with key_extended=1 is ignored, except DEL (0x71), which is mapped both ways; arrows are mapped only as extended.
REQ-020 SHALL hold a NUM_COLS×NUM_ROWS bit array: a strobe with a hit sets bit[col][row] on make and clears it on break, with effect on the next clk_24 edge.
REQ-021 SHALL register row_n only on clk_24 edges where clk_en=1: row_n[r] = ~bit[col][r]; latency is one enabled edge.
REQ-022 SHALL OR all simultaneously held keys in the selected column, with no priority encoding (e.g. SHIFT+L → both rows low).
REQ-023 SHALL drive row_n all-ones when col ≥ NUM_COLS.
REQ-024 SHALL set any_key = OR of the array, combinational from registers.
REQ-025 swrst SHALL assert on an RST make, stay asserted while RST is held, and deassert on the later of RST break and STRETCH cycles after the make.
REQ-026 swnmi SHALL assert for exactly STRETCH cycles per NMI make; repeated makes (typematic) while asserted or held SHALL NOT retrigger; retriggering requires an intervening break.
REQ-027 The stuck counter SHALL reset on any strobe or when any_key=0, and SHALL increment on clk_en while any_key=1; on reaching STUCK_TICKS it SHALL clear the array and the RST/NMI held flags, then restart from 0.
REQ-028 release_all=1 SHALL clear the array and held flags every cycle it is high; it wins over a coincident strobe. Stretch counters already running SHALL complete.
REQ-029 A make for an already-set key and a break for a clear key SHALL be no-ops.

Reset
REQ-030 reset_n=0 SHALL asynchronously clear the array, held flags, stretch and stuck counters, and set swrst=0, swnmi=0, any_key=0, row_n=all-ones.
REQ-031 Reset SHALL override any in-flight stretch, so outputs are low on the first edge after release.

Structure
REQ-032 kbd_pkg SHALL hold the keymap entry typedef {hit, special[1:0], col[3:0], row[3:0]}, the special enums (NONE, RST, NMI) and the scan-code constants.
REQ-033 The sub-module kbd_keymap SHALL be purely combinational, mapping {extended, code} to a keymap entry; the Oric default layout is the parameter-free instance.

Verification
REQ-034 Scenario: make 0x4B (L) then 0x59 (RSHIFT); col=7, clk_en pulse → row_n=8'b11101101; break L → row_n=8'b11101111.
REQ-035 Scenario: extended 0x75 (up); col=4 → row_n=8'b11110111; non-extended 0x75 → no change.
REQ-036 Scenario: F10 make, STRETCH=16, then a repeated make at cycle 5 → swnmi high for exactly 16 cycles, single pulse.
REQ-037 Scenario: F11 make, break after 3 cycles → swrst high for 16 cycles; break after 40 cycles → swrst high for 40 cycles.
REQ-038 Scenario: STUCK_TICKS=4, A held, no strobes, clk_en every cycle → array cleared after 4 ticks and any_key=0.
REQ-039 Scenario: release_all coincident with a make of Q, then reset_n pulsed mid-swnmi stretch → Q not set; swnmi=0 and row_n=FF immediately.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_pkg -- shared types and constants for the PS/2 to Oric keyboard matrix.
//   special_t       : NONE / RST / NMI classification of a decoded key
//   keymap_entry_t  : {hit, special[1:0], col[3:0], row[3:0]}
//   SC_*            : PS/2 set-2 scan codes with special meaning
//   key_at/key_spec : helpers to build keymap entries
package kbd_pkg;

   typedef enum logic [1:0] {
      SP_NONE = 2'd0,
      SP_RST  = 2'd1,
      SP_NMI  = 2'd2
   } special_t;

   typedef struct packed {
      logic       hit;
      special_t   special;
      logic [3:0] col;
      logic [3:0] row;
   } keymap_entry_t;

   localparam logic [7:0] SC_F10   = 8'h09;
   localparam logic [7:0] SC_F11   = 8'h78;
   localparam logic [7:0] SC_DEL   = 8'h71;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   localparam keymap_entry_t KEY_NONE = '{hit: 1'b0, special: SP_NONE, col: 4'd0, row: 4'd0};

   function automatic keymap_entry_t key_at(input logic [3:0] c, input logic [3:0] r);
      key_at = '{hit: 1'b1, special: SP_NONE, col: c, row: r};
   endfunction

   function automatic keymap_entry_t key_spec(input special_t s);
      key_spec = '{hit: 1'b1, special: s, col: 4'd0, row: 4'd0};
   endfunction

endpackage

// File: rtl/kbd_keymap.sv
// kbd_keymap -- combinational PS/2 scan code to Oric matrix position.
//   extended : code was preceded by E0
//   code     : set-2 scan code
//   entry    : {hit, special, col, row}; hit=0 for unmapped codes
// The case key includes the extended bit, so a normal key arriving with E0
// simply misses. DEL is listed under both prefixes; arrows only under E0.
module kbd_keymap
   import kbd_pkg::*;
(
   input  logic          extended,
   input  logic [7:0]    code,
   output keymap_entry_t entry
);

   always_comb begin
      entry = KEY_NONE;
      case ({extended, code})
         // column 0
         9'h026: entry = key_at(4'd0, 4'd0);   // 3
         9'h022: entry = key_at(4'd0, 4'd1);   // X
         9'h016: entry = key_at(4'd0, 4'd2);   // 1
         9'h02A: entry = key_at(4'd0, 4'd4);   // V
         9'h02E: entry = key_at(4'd0, 4'd5);   // 5
         9'h031: entry = key_at(4'd0, 4'd6);   // N
         9'h03D: entry = key_at(4'd0, 4'd7);   // 7
         // column 1
         9'h023: entry = key_at(4'd1, 4'd0);   // D
         9'h015: entry = key_at(4'd1, 4'd1);   // Q
         9'h076: entry = key_at(4'd1, 4'd2);   // ESC
         9'h02B: entry = key_at(4'd1, 4'd4);   // F
         9'h02D: entry = key_at(4'd1, 4'd5);   // R
         9'h02C: entry = key_at(4'd1, 4'd6);   // T
         9'h03B: entry = key_at(4'd1, 4'd7);   // J
         // column 2
         9'h021: entry = key_at(4'd2, 4'd0);   // C
         9'h01E: entry = key_at(4'd2, 4'd1);   // 2
         9'h01A: entry = key_at(4'd2, 4'd2);   // Z
         9'h014: entry = key_at(4'd2, 4'd3);   // LCTRL
         9'h025: entry = key_at(4'd2, 4'd4);   // 4
         9'h032: entry = key_at(4'd2, 4'd5);   // B
         9'h036: entry = key_at(4'd2, 4'd6);   // 6
         9'h03A: entry = key_at(4'd2, 4'd7);   // M
         // column 3
         9'h052: entry = key_at(4'd3, 4'd0);   // '
         9'h05D: entry = key_at(4'd3, 4'd1);   // backslash
         9'h04E: entry = key_at(4'd3, 4'd4);   // -
         9'h04C: entry = key_at(4'd3, 4'd5);   // ;
         9'h046: entry = key_at(4'd3, 4'd6);   // 9
         9'h042: entry = key_at(4'd3, 4'd7);   // K
         // column 4
         {1'b1, SC_RIGHT}: entry = key_at(4'd4, 4'd0);
         {1'b1, SC_DOWN}:  entry = key_at(4'd4, 4'd1);
         {1'b1, SC_LEFT}:  entry = key_at(4'd4, 4'd2);
         {1'b1, SC_UP}:    entry = key_at(4'd4, 4'd3);
         9'h012: entry = key_at(4'd4, 4'd4);   // LSHIFT
         9'h049: entry = key_at(4'd4, 4'd5);   // .
         9'h041: entry = key_at(4'd4, 4'd6);   // ,
         9'h029: entry = key_at(4'd4, 4'd7);   // SPACE
         // column 5
         9'h054: entry = key_at(4'd5, 4'd0);   // [
         9'h05B: entry = key_at(4'd5, 4'd1);   // ]
         {1'b0, SC_DEL}, {1'b1, SC_DEL}: entry = key_at(4'd5, 4'd2);
         9'h011: entry = key_at(4'd5, 4'd3);   // LALT as FUNCT
         9'h04D: entry = key_at(4'd5, 4'd4);   // P
         9'h044: entry = key_at(4'd5, 4'd5);   // O
         9'h043: entry = key_at(4'd5, 4'd6);   // I
         9'h03C: entry = key_at(4'd5, 4'd7);   // U
         // column 6
         9'h01D: entry = key_at(4'd6, 4'd0);   // W
         9'h01B: entry = key_at(4'd6, 4'd1);   // S
         9'h01C: entry = key_at(4'd6, 4'd2);   // A
         9'h024: entry = key_at(4'd6, 4'd4);   // E
         9'h034: entry = key_at(4'd6, 4'd5);   // G
         9'h033: entry = key_at(4'd6, 4'd6);   // H
         9'h035: entry = key_at(4'd6, 4'd7);   // Y
         // column 7
         9'h055: entry = key_at(4'd7, 4'd0);   // =
         9'h04B: entry = key_at(4'd7, 4'd1);   // L
         9'h03E: entry = key_at(4'd7, 4'd2);   // 8
         9'h04A: entry = key_at(4'd7, 4'd3);   // /
         9'h059: entry = key_at(4'd7, 4'd4);   // RSHIFT
         9'h05A: entry = key_at(4'd7, 4'd5);   // ENTER
         9'h045: entry = key_at(4'd7, 4'd6);   // 0
         // specials
         {1'b0, SC_F11}: entry = key_spec(SP_RST);
         {1'b0, SC_F10}: entry = key_spec(SP_NMI);
         default: entry = KEY_NONE;
      endcase
   end

endmodule

// File: rtl/kbd_matrix.sv
// kbd_matrix -- PS/2 key events to an Oric-style scanned keyboard matrix.
//   clk_24, reset_n (async, active-low)
//   clk_en       : matrix sample enable; row_n and the stuck counter advance on it
//   key_strobe/key_pressed/key_extended/key_code : one decoded PS/2 event
//   release_all  : level, clears every held key (wins over a coincident event)
//   col          : column being scanned
//   row_n        : active-low rows of the selected column, registered on clk_en
//   any_key      : OR of the whole matrix
//   swrst/swnmi  : stretched reset request / NMI pulse from F11 / F10
module kbd_matrix
   import kbd_pkg::*;
#(
   parameter int NUM_COLS    = 8,
   parameter int NUM_ROWS    = 8,
   parameter int STRETCH     = 16,
   parameter int STUCK_TICKS = 65535
)(
   input  logic                        clk_24,
   input  logic                        reset_n,
   input  logic                        clk_en,
   input  logic                        key_strobe,
   input  logic                        key_pressed,
   input  logic                        key_extended,
   input  logic [7:0]                  key_code,
   input  logic                        release_all,
   input  logic [$clog2(NUM_COLS)-1:0] col,
   output logic [NUM_ROWS-1:0]         row_n,
   output logic                        any_key,
   output logic                        swrst,
   output logic                        swnmi
);

   localparam int SW = $clog2(STRETCH + 1);
   localparam int TW = (STUCK_TICKS > 0) ? $clog2(STUCK_TICKS + 1) : 1;

   keymap_entry_t       ent;
   logic                ev_valid, hit_ok, rst_ev, nmi_ev;
   logic                rst_load, nmi_load, stuck_fire, clear_all;
   logic                rst_held_reg, nmi_held_reg, rst_held_next, nmi_held_next;
   logic [SW-1:0]       rst_cnt_reg, nmi_cnt_reg;
   logic [TW-1:0]       stuck_reg;
   logic [NUM_ROWS-1:0] row_mask;
   logic [NUM_ROWS-1:0] col_bits [NUM_COLS];
   logic [NUM_COLS-1:0] col_any;

   kbd_keymap u_keymap (
      .extended (key_extended),
      .code     (key_code),
      .entry    (ent)
   );

   assign ev_valid = key_strobe && !release_all;
   // Positions outside a reduced matrix are silently dropped.
   assign hit_ok   = ent.hit && (ent.special == SP_NONE) &&
                     (32'(ent.col) < NUM_COLS) && (32'(ent.row) < NUM_ROWS);
   assign rst_ev   = ev_valid && ent.hit && (ent.special == SP_RST);
   assign nmi_ev   = ev_valid && ent.hit && (ent.special == SP_NMI);

   // Stretches start only from the released state, so typematic repeats are ignored.
   assign rst_load = rst_ev && key_pressed && !rst_held_reg;
   assign nmi_load = nmi_ev && key_pressed && !nmi_held_reg && !swnmi;

   // Any event restarts the stuck timeout, so it cannot fire on a strobe cycle.
   assign stuck_fire = (STUCK_TICKS != 0) && !key_strobe && any_key && clk_en &&
                       (32'(stuck_reg) == STUCK_TICKS - 1);
   assign clear_all  = release_all || stuck_fire;

   always_comb begin
      row_mask = '0;
      if (ev_valid && hit_ok)
         row_mask = NUM_ROWS'(1) << ent.row;
   end

   for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
      logic [NUM_ROWS-1:0] bits_reg;
      always_ff @(posedge clk_24 or negedge reset_n) begin
         if (!reset_n)
            bits_reg <= '0;
         else if (clear_all)
            bits_reg <= '0;
         else if (32'(ent.col) == gi)
            bits_reg <= key_pressed ? (bits_reg | row_mask) : (bits_reg & ~row_mask);
      end
      assign col_bits[gi] = bits_reg;
      assign col_any[gi]  = |bits_reg;
   end

   assign any_key = |col_any;

   always_ff @(posedge clk_24 or negedge reset_n) begin
      if (!reset_n)
         row_n <= '1;
      else if (clk_en)
         row_n <= (32'(col) < NUM_COLS) ? ~col_bits[col] : '1;
   end

   always_ff @(posedge clk_24 or negedge reset_n) begin
      if (!reset_n)
         stuck_reg <= '0;
      else if (key_strobe || !any_key || stuck_fire)
         stuck_reg <= '0;
      else if (clk_en)
         stuck_reg <= stuck_reg + 1'b1;
   end

   always_comb begin
      rst_held_next = rst_held_reg;
      nmi_held_next = nmi_held_reg;
      if (clear_all) begin
         rst_held_next = 1'b0;
         nmi_held_next = 1'b0;
      end else begin
         if (rst_ev) rst_held_next = key_pressed;
         if (nmi_ev) nmi_held_next = key_pressed;
      end
   end

   // Counters hold the cycles remaining after the current one; release_all
   // does not touch them, so a running stretch always completes.
   always_ff @(posedge clk_24 or negedge reset_n) begin
      if (!reset_n) begin
         rst_held_reg <= 1'b0;
         nmi_held_reg <= 1'b0;
         rst_cnt_reg  <= '0;
         nmi_cnt_reg  <= '0;
         swrst        <= 1'b0;
         swnmi        <= 1'b0;
      end else begin
         rst_held_reg <= rst_held_next;
         nmi_held_reg <= nmi_held_next;
         if (rst_load)
            rst_cnt_reg <= SW'(STRETCH - 1);
         else if (rst_cnt_reg != '0)
            rst_cnt_reg <= rst_cnt_reg - 1'b1;
         if (nmi_load)
            nmi_cnt_reg <= SW'(STRETCH - 1);
         else if (nmi_cnt_reg != '0)
            nmi_cnt_reg <= nmi_cnt_reg - 1'b1;
         swrst <= rst_load || rst_held_next || (rst_cnt_reg != '0);
         swnmi <= nmi_load || (nmi_cnt_reg != '0);
      end
   end

endmodule

// File: tb/tb_kbd_matrix.sv
// tb_kbd_matrix -- directed scenarios plus randomized events for kbd_matrix,
// checked every cycle against a behavioural model built from key tables,
// per-position bits and time stamps for the stretched outputs.
`timescale 1ns/1ps
module tb_kbd_matrix;

   localparam int NC  = 8;
   localparam int NR  = 8;
   localparam int ST  = 16;
   localparam int STK = 4;
   localparam int K_KEY = 0, K_RST = 1, K_NMI = 2;

   logic       clk_24 = 1'b0, reset_n = 1'b0, clk_en = 1'b0;
   logic       key_strobe = 1'b0, key_pressed = 1'b0, key_extended = 1'b0, release_all = 1'b0;
   logic [7:0] key_code = 8'h00;
   logic [2:0] col = 3'd0;
   logic [7:0] row_n, row_n6;
   logic       any_key, swrst, swnmi, any_key6, swrst6, swnmi6;

   always #5 clk_24 = ~clk_24;

   kbd_matrix #(.NUM_COLS(NC), .NUM_ROWS(NR), .STRETCH(ST), .STUCK_TICKS(STK)) dut (
      .clk_24(clk_24), .reset_n(reset_n), .clk_en(clk_en), .key_strobe(key_strobe),
      .key_pressed(key_pressed), .key_extended(key_extended), .key_code(key_code),
      .release_all(release_all), .col(col), .row_n(row_n), .any_key(any_key),
      .swrst(swrst), .swnmi(swnmi));

   // Narrow matrix: columns 6 and 7 do not exist, so selecting them reads all-ones.
   kbd_matrix #(.NUM_COLS(6), .NUM_ROWS(NR), .STRETCH(ST), .STUCK_TICKS(0)) dut6 (
      .clk_24(clk_24), .reset_n(reset_n), .clk_en(clk_en), .key_strobe(key_strobe),
      .key_pressed(key_pressed), .key_extended(key_extended), .key_code(key_code),
      .release_all(release_all), .col(col), .row_n(row_n6), .any_key(any_key6),
      .swrst(swrst6), .swnmi(swnmi6));

   typedef struct {
      logic [7:0] code;
      bit         ext;
      bit         both;
      int         kind;
      int         c;
      int         r;
   } map_t;

   map_t keymap_q[$];

   int total = 0, bad = 0, cyc = 0;
   bit m_key [NC][NR];
   bit m_hrst, m_hnmi;
   int m_tick, rst_end, nmi_end;
   logic [7:0] exp_row;
   bit exp6_valid;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic add(input logic [7:0] code, input bit ext, input bit both,
                      input int kind, input int c, input int r);
      map_t m;
      m.code = code; m.ext = ext; m.both = both; m.kind = kind; m.c = c; m.r = r;
      keymap_q.push_back(m);
   endtask

   task automatic init_map();
      add(8'h4B, 0, 0, K_KEY, 7, 1);  // L
      add(8'h59, 0, 0, K_KEY, 7, 4);  // RSHIFT
      add(8'h5A, 0, 0, K_KEY, 7, 5);  // ENTER
      add(8'h45, 0, 0, K_KEY, 7, 6);  // 0
      add(8'h75, 1, 0, K_KEY, 4, 3);  // up
      add(8'h6B, 1, 0, K_KEY, 4, 2);  // left
      add(8'h12, 0, 0, K_KEY, 4, 4);  // LSHIFT
      add(8'h29, 0, 0, K_KEY, 4, 7);  // space
      add(8'h1C, 0, 0, K_KEY, 6, 2);  // A
      add(8'h15, 0, 0, K_KEY, 1, 1);  // Q
      add(8'h23, 0, 0, K_KEY, 1, 0);  // D
      add(8'h71, 0, 1, K_KEY, 5, 2);  // DEL, both prefixes
      add(8'h1A, 0, 0, K_KEY, 2, 2);  // Z
      add(8'h4E, 0, 0, K_KEY, 3, 4);  // -
      add(8'h26, 0, 0, K_KEY, 0, 0);  // 3
      add(8'h78, 0, 0, K_RST, 0, 0);  // F11
      add(8'h09, 0, 0, K_NMI, 0, 0);  // F10
   endtask

   function automatic int lookup(input logic [7:0] code, input bit ext);
      foreach (keymap_q[i])
         if (keymap_q[i].code == code && (keymap_q[i].both || keymap_q[i].ext == ext))
            return i;
      return -1;
   endfunction

   function automatic bit model_any();
      bit a = 0;
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < NR; r++)
            a |= m_key[c][r];
      return a;
   endfunction

   task automatic clear_keys();
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < NR; r++)
            m_key[c][r] = 0;
      m_hrst = 0;
      m_hnmi = 0;
   endtask

   task automatic model_reset();
      clear_keys();
      m_tick = 0;
      rst_end = cyc;
      nmi_end = cyc;
      exp_row = 8'hFF;
      exp6_valid = 1;
   endtask

   // One rising edge of the reference: cyc is the index of this edge.
   task automatic model_edge();
      bit any_pre, nmi_active_pre, fire;
      int idx;
      any_pre = model_any();
      nmi_active_pre = (cyc - 1) < nmi_end;
      if (clk_en) begin
         for (int r = 0; r < NR; r++) exp_row[r] = ~m_key[col][r];
         exp6_valid = (col >= 6);
      end
      fire = (STK > 0) && !key_strobe && any_pre && clk_en && (m_tick + 1 == STK);
      if (key_strobe || !any_pre || fire) m_tick = 0;
      else if (clk_en) m_tick++;
      if (release_all || fire) begin
         clear_keys();
      end else if (key_strobe) begin
         idx = lookup(key_code, key_extended);
         if (idx >= 0) begin
            case (keymap_q[idx].kind)
               K_KEY: m_key[keymap_q[idx].c][keymap_q[idx].r] = key_pressed;
               K_RST: begin
                  if (key_pressed && !m_hrst) rst_end = cyc + ST;
                  m_hrst = key_pressed;
               end
               default: begin
                  if (key_pressed && !m_hnmi && !nmi_active_pre) nmi_end = cyc + ST;
                  m_hnmi = key_pressed;
               end
            endcase
         end
      end
   endtask

   task automatic tick();
      @(posedge clk_24);
      cyc++;
      if (reset_n) model_edge();
      #1;
      check("row_n", 32'(row_n), 32'(exp_row));
      check("any_key", 32'(any_key), 32'(model_any()));
      check("swrst", 32'(swrst), 32'(m_hrst || (cyc < rst_end)));
      check("swnmi", 32'(swnmi), 32'(cyc < nmi_end));
      if (exp6_valid) check("row_n_narrow", 32'(row_n6), 32'hFF);
   endtask

   task automatic step(input bit s, input bit p, input bit e, input logic [7:0] code,
                       input bit ce, input bit ra, input logic [2:0] c);
      key_strobe = s; key_pressed = p; key_extended = e; key_code = code;
      clk_en = ce; release_all = ra; col = c;
      tick();
      key_strobe = 0; release_all = 0; clk_en = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 0, 0, col);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int hi, rises, brk;
      bit prev;
      logic [7:0] unm [6];
      unm[0] = 8'h05; unm[1] = 8'h06; unm[2] = 8'h04;
      unm[3] = 8'h0C; unm[4] = 8'h03; unm[5] = 8'h83;

      init_map();
      model_reset();
      tick();
      tick();
      check("reset_row_n", 32'(row_n), 32'hFF);
      reset_n = 1;
      idle(2);

      // L + RSHIFT in column 7, then release L
      step(1, 1, 0, 8'h4B, 0, 0, 7);
      step(1, 1, 0, 8'h59, 0, 0, 7);
      step(0, 0, 0, 8'h00, 1, 0, 7);
      check("l_rshift", 32'(row_n), 32'b11101101);
      step(1, 0, 0, 8'h4B, 0, 0, 7);
      step(0, 0, 0, 8'h00, 1, 0, 7);
      check("rshift_only", 32'(row_n), 32'b11101111);
      step(1, 0, 0, 8'h59, 0, 0, 7);

      // Up arrow is extended only; a plain 0x75 break must not release it
      step(1, 1, 1, 8'h75, 0, 0, 4);
      step(0, 0, 0, 8'h00, 1, 0, 4);
      check("up_ext", 32'(row_n), 32'b11110111);
      step(1, 0, 0, 8'h75, 0, 0, 4);
      step(0, 0, 0, 8'h00, 1, 0, 4);
      check("up_plain_ignored", 32'(row_n), 32'b11110111);
      step(1, 0, 1, 8'h75, 0, 0, 4);
      step(0, 0, 0, 8'h00, 1, 0, 6);
      check("narrow_col6", 32'(row_n6), 32'hFF);

      // NMI: typematic repeat at cycle 5 must not extend or retrigger
      idle(2);
      step(1, 1, 0, 8'h09, 0, 0, 0);
      hi = swnmi; rises = swnmi; prev = swnmi;
      for (int k = 1; k <= 30; k++) begin
         if (k == 5) step(1, 1, 0, 8'h09, 0, 0, 0);
         else idle(1);
         hi += swnmi;
         if (swnmi && !prev) rises++;
         prev = swnmi;
      end
      check("nmi_width", 32'(hi), 32'(ST));
      check("nmi_pulses", 32'(rises), 32'd1);
      step(1, 0, 0, 8'h09, 0, 0, 0);

      // RST: short hold stretched to STRETCH, long hold follows the key
      foreach (unm[i]) begin end
      for (int t = 0; t < 2; t++) begin
         brk = (t == 0) ? 3 : 40;
         step(1, 1, 0, 8'h78, 0, 0, 0);
         hi = swrst;
         for (int k = 1; k <= 60; k++) begin
            if (k == brk) step(1, 0, 0, 8'h78, 0, 0, 0);
            else idle(1);
            hi += swrst;
         end
         check("rst_width", 32'(hi), 32'((t == 0) ? ST : 40));
      end

      // Stuck key auto-release after STK enabled ticks without a strobe
      step(1, 1, 0, 8'h1C, 0, 0, 6);
      for (int k = 1; k <= 3; k++) step(0, 0, 0, 8'h00, 1, 0, 6);
      check("stuck_held", 32'(any_key), 32'd1);
      step(0, 0, 0, 8'h00, 1, 0, 6);
      check("stuck_released", 32'(any_key), 32'd0);
      idle(1);

      // release_all beats a coincident make; then reset mid NMI stretch
      step(1, 1, 0, 8'h15, 0, 1, 1);
      step(0, 0, 0, 8'h00, 1, 0, 1);
      check("ra_wins", 32'(row_n), 32'hFF);
      step(1, 1, 0, 8'h15, 0, 0, 1);
      step(0, 0, 0, 8'h00, 1, 0, 1);
      check("q_set", 32'(row_n), 32'b11111101);
      step(1, 1, 0, 8'h09, 0, 0, 1);
      idle(3);
      check("nmi_before_reset", 32'(swnmi), 32'd1);
      #2;
      reset_n = 0;
      #1;
      check("async_swnmi", 32'(swnmi), 32'd0);
      check("async_row_n", 32'(row_n), 32'hFF);
      check("async_any_key", 32'(any_key), 32'd0);
      model_reset();
      idle(2);
      reset_n = 1;
      idle(2);

      // Randomized events
      for (int i = 0; i < 3000; i++) begin
         bit s, p, e, ce, ra;
         logic [7:0] code;
         logic [2:0] c;
         int j;
         s  = $urandom_range(0, 99) < 35;
         p  = $urandom_range(0, 99) < 55;
         ra = $urandom_range(0, 99) < 3;
         ce = $urandom_range(0, 1) == 1;
         c  = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 99) < 15) begin
            code = unm[$urandom_range(0, 5)];
            e = $urandom_range(0, 3) == 0;
         end else begin
            j = $urandom_range(0, keymap_q.size() - 1);
            code = keymap_q[j].code;
            e = keymap_q[j].ext ^ ($urandom_range(0, 4) == 0);
         end
         if (i == 1500) begin
            reset_n = 0;
            model_reset();
            idle(1);
            reset_n = 1;
         end
         step(s, p, e, code, ce, ra, c);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
